// File: rtl/dnn2ami_port_arbiter_pkg.sv
// Shared AMI request types and arbiter constants for the DNN-to-AMI port arbiter.
package dnn2ami_port_arbiter_pkg;

    localparam int unsigned AMI_ADDR_W = 64;
    localparam int unsigned AMI_SIZE_W = 8;

    typedef struct packed {
        logic                  valid;
        logic                  isWrite;
        logic [AMI_ADDR_W-1:0] addr;
        logic [AMI_SIZE_W-1:0] size;
    } AMIRequest;

    typedef enum logic {ARB_RD = 1'b0, ARB_WR = 1'b1} DNNArbOwner;

    localparam int unsigned DNN_ARB_MAX_BURST = 8;

endpackage

// File: rtl/dnn2ami_port_arbiter_if.sv
// Valid/request/grant channel; master drives the request, slave returns the grant.
interface dnn2ami_port_arbiter_if;
    import dnn2ami_port_arbiter_pkg::*;

    logic      reqValid;
    AMIRequest req;
    logic      grant;

    modport master (output reqValid, output req, input grant);
    modport slave  (input reqValid, input req, output grant);

endinterface

// File: rtl/dnn2ami_port_arbiter_sel.sv
// Two-way round-robin picker that hands the port over once a burst limit is reached.
module dnn_rr2_burst_sel
    import dnn2ami_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = DNN_ARB_MAX_BURST,
    parameter int unsigned BURST_W   = $clog2(MAX_BURST) + 1
) (
    input  logic [1:0]         req_i,
    input  DNNArbOwner         last_owner_i,
    input  logic [BURST_W-1:0] burst_cnt_i,
    input  logic               en_i,
    output logic               win_valid_o,
    output DNNArbOwner         win_id_o
);

    logic       hand_over_c;
    DNNArbOwner other_c;

    // An empty burst (just out of reset) or an exhausted one gives the tie to the other path.
    assign hand_over_c = (burst_cnt_i == '0) || (burst_cnt_i >= BURST_W'(MAX_BURST));
    assign other_c     = (last_owner_i == ARB_RD) ? ARB_WR : ARB_RD;

    always_comb begin
        win_valid_o = 1'b0;
        win_id_o    = ARB_RD;
        if (en_i) begin
            case (req_i)
                2'b01: begin
                    win_valid_o = 1'b1;
                    win_id_o    = ARB_RD;
                end
                2'b10: begin
                    win_valid_o = 1'b1;
                    win_id_o    = ARB_WR;
                end
                2'b11: begin
                    win_valid_o = 1'b1;
                    win_id_o    = hand_over_c ? other_c : last_owner_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dnn2ami_port_arbiter.sv
// Shares the AMI request port between the DNN read and write paths through a one-entry slot.
module dnn2ami_port_arbiter
    import dnn2ami_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = DNN_ARB_MAX_BURST,
    parameter int unsigned BURST_W   = $clog2(MAX_BURST) + 1,
    parameter int unsigned STAT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    dnn2ami_port_arbiter_if.slave  rd_i,
    dnn2ami_port_arbiter_if.slave  wr_i,
    dnn2ami_port_arbiter_if.master ami_o,
    input  logic                  quiesce_i,
    output logic                  idle_o,
    output logic [STAT_W-1:0]     rd_grant_cnt_o,
    output logic [STAT_W-1:0]     wr_grant_cnt_o
);

    logic               slot_valid_q, slot_valid_d;
    AMIRequest          slot_q, slot_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    DNNArbOwner         owner_q, owner_d;
    logic [STAT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [STAT_W-1:0]  wr_cnt_q, wr_cnt_d;

    logic [1:0] req_c;
    logic       load_en_c;
    logic       win_valid_c;
    DNNArbOwner win_id_c;
    AMIRequest  win_req_c;

    // A request only counts when both the port valid and the payload valid are set.
    assign req_c     = {wr_i.reqValid & wr_i.req.valid, rd_i.reqValid & rd_i.req.valid};
    assign load_en_c = (!slot_valid_q || ami_o.grant) && !quiesce_i;

    dnn_rr2_burst_sel #(
        .MAX_BURST (MAX_BURST),
        .BURST_W   (BURST_W)
    ) u_sel (
        .req_i        (req_c),
        .last_owner_i (owner_q),
        .burst_cnt_i  (burst_q),
        .en_i         (load_en_c),
        .win_valid_o  (win_valid_c),
        .win_id_o     (win_id_c)
    );

    assign rd_i.grant = win_valid_c && (win_id_c == ARB_RD);
    assign wr_i.grant = win_valid_c && (win_id_c == ARB_WR);

    always_comb begin
        win_req_c = rd_i.req;
        if (win_id_c == ARB_WR) begin
            win_req_c = wr_i.req;
        end
        win_req_c.valid = 1'b1;
    end

    // Next-state for slot, burst tracking and statistics.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_d       = slot_q;
        burst_d      = burst_q;
        owner_d      = owner_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        if (win_valid_c) begin
            slot_valid_d = 1'b1;
            slot_d       = win_req_c;
            if (win_id_c == ARB_RD) begin
                rd_cnt_d = rd_cnt_q + STAT_W'(1);
            end else begin
                wr_cnt_d = wr_cnt_q + STAT_W'(1);
            end
            if (win_id_c == owner_q) begin
                burst_d = (burst_q >= BURST_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                           : burst_q + BURST_W'(1);
            end else begin
                burst_d = BURST_W'(1);
                owner_d = win_id_c;
            end
        end else if (slot_valid_q && ami_o.grant) begin
            slot_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
            burst_q      <= '0;
            owner_q      <= ARB_WR;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_q       <= slot_d;
            burst_q      <= burst_d;
            owner_q      <= owner_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign ami_o.reqValid = slot_valid_q;
    assign ami_o.req      = slot_q;
    assign idle_o         = !slot_valid_q && (quiesce_i || !(rd_i.reqValid || wr_i.reqValid));
    assign rd_grant_cnt_o = rd_cnt_q;
    assign wr_grant_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_dnn2ami_port_arbiter.sv
// Directed self-checking bench for dnn2ami_port_arbiter.
module tb_dnn2ami_port_arbiter;
    import dnn2ami_port_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        quiesce;
    logic        idle;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int passed;
    int total;

    dnn2ami_port_arbiter_if rd_if ();
    dnn2ami_port_arbiter_if wr_if ();
    dnn2ami_port_arbiter_if ami_if ();

    dnn2ami_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .rd_i           (rd_if),
        .wr_i           (wr_if),
        .ami_o          (ami_if),
        .quiesce_i      (quiesce),
        .idle_o         (idle),
        .rd_grant_cnt_o (rd_cnt),
        .wr_grant_cnt_o (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic AMIRequest mk(input logic [63:0] a, input logic v, input logic w);
        AMIRequest r;
        r         = '0;
        r.valid   = v;
        r.isWrite = w;
        r.addr    = a;
        r.size    = 8'd8;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rd_if.reqValid  = 1'b0;
        rd_if.req       = '0;
        wr_if.reqValid  = 1'b0;
        wr_if.req       = '0;
        ami_if.grant    = 1'b0;
        quiesce         = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (ami_if.reqValid !== 1'b0) $display("FAIL reset_reqValid got %b exp 0", ami_if.reqValid);
        else passed++;
        total++;
        if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) $display("FAIL reset_cnts got %0d/%0d exp 0/0", rd_cnt, wr_cnt);
        else passed++;
        total++;
        if (idle !== 1'b1) $display("FAIL reset_idle got %b exp 1", idle);
        else passed++;
        next_cycle();
    endtask

    task automatic test_rd_only();
        logic [63:0] exp_addr;
        do_reset();
        ami_if.grant = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rd_if.reqValid = (c < 3);
            rd_if.req      = mk(64'h100 + 64'(8 * c), 1'b1, 1'b0);
            #1;
            total++;
            if (rd_if.grant !== (c < 3)) $display("FAIL rd_only_grant c%0d got %b exp %b", c, rd_if.grant, (c < 3));
            else passed++;
            total++;
            if (ami_if.reqValid !== (c >= 1 && c <= 3))
                $display("FAIL rd_only_reqValid c%0d got %b exp %b", c, ami_if.reqValid, (c >= 1 && c <= 3));
            else passed++;
            if (c >= 1 && c <= 3) begin
                exp_addr = 64'h100 + 64'(8 * (c - 1));
                total++;
                if (ami_if.req.addr !== exp_addr || ami_if.req.valid !== 1'b1)
                    $display("FAIL rd_only_addr c%0d got %h exp %h", c, ami_if.req.addr, exp_addr);
                else passed++;
            end
            next_cycle();
        end
        total++;
        if (rd_cnt !== 32'd3 || wr_cnt !== 32'd0) $display("FAIL rd_only_cnt got %0d/%0d exp 3/0", rd_cnt, wr_cnt);
        else passed++;
    endtask

    task automatic test_both_burst();
        logic exp_wr;
        logic prev_wr;
        do_reset();
        ami_if.grant   = 1'b1;
        rd_if.reqValid = 1'b1;
        rd_if.req      = mk(64'h200, 1'b1, 1'b0);
        wr_if.reqValid = 1'b1;
        wr_if.req      = mk(64'h300, 1'b1, 1'b1);
        prev_wr        = 1'b0;
        for (int c = 0; c < 24; c++) begin
            exp_wr = (c >= 8 && c < 16);
            #1;
            total++;
            if (rd_if.grant !== !exp_wr || wr_if.grant !== exp_wr)
                $display("FAIL burst_grant c%0d got rd=%b wr=%b exp rd=%b wr=%b",
                         c, rd_if.grant, wr_if.grant, !exp_wr, exp_wr);
            else passed++;
            if (c >= 1) begin
                total++;
                if (ami_if.reqValid !== 1'b1 || ami_if.req.isWrite !== prev_wr)
                    $display("FAIL burst_out c%0d got v=%b w=%b exp v=1 w=%b",
                             c, ami_if.reqValid, ami_if.req.isWrite, prev_wr);
                else passed++;
            end
            prev_wr = exp_wr;
            next_cycle();
        end
        total++;
        if (rd_cnt !== 32'd16 || wr_cnt !== 32'd8) $display("FAIL burst_cnt got %0d/%0d exp 16/8", rd_cnt, wr_cnt);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        ami_if.grant   = 1'b1;
        rd_if.reqValid = 1'b1;
        rd_if.req      = mk(64'h200, 1'b1, 1'b0);
        wr_if.reqValid = 1'b1;
        wr_if.req      = mk(64'h300, 1'b1, 1'b1);
        #1;
        total++;
        if (rd_if.grant !== 1'b1) $display("FAIL stall_first got %b exp 1", rd_if.grant);
        else passed++;
        next_cycle();
        ami_if.grant = 1'b0;
        rd_if.req    = mk(64'h208, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (rd_if.grant !== 1'b0 || wr_if.grant !== 1'b0)
                $display("FAIL stall_nogrant c%0d got rd=%b wr=%b exp 0/0", c, rd_if.grant, wr_if.grant);
            else passed++;
            total++;
            if (ami_if.reqValid !== 1'b1 || ami_if.req.addr !== 64'h200)
                $display("FAIL stall_hold c%0d got v=%b a=%h exp v=1 a=200", c, ami_if.reqValid, ami_if.req.addr);
            else passed++;
            next_cycle();
        end
        ami_if.grant = 1'b1;
        #1;
        total++;
        if (rd_if.grant !== 1'b1 || wr_if.grant !== 1'b0)
            $display("FAIL stall_release got rd=%b wr=%b exp 1/0", rd_if.grant, wr_if.grant);
        else passed++;
        next_cycle();
        total++;
        if (ami_if.reqValid !== 1'b1 || ami_if.req.addr !== 64'h208)
            $display("FAIL stall_reload got v=%b a=%h exp v=1 a=208", ami_if.reqValid, ami_if.req.addr);
        else passed++;
    endtask

    task automatic test_quiesce();
        do_reset();
        wr_if.reqValid = 1'b1;
        wr_if.req      = mk(64'h400, 1'b1, 1'b1);
        #1;
        total++;
        if (wr_if.grant !== 1'b1) $display("FAIL quiesce_load got %b exp 1", wr_if.grant);
        else passed++;
        next_cycle();
        wr_if.req = mk(64'h408, 1'b1, 1'b1);
        quiesce   = 1'b1;
        #1;
        total++;
        if (wr_if.grant !== 1'b0 || ami_if.reqValid !== 1'b1 || idle !== 1'b0)
            $display("FAIL quiesce_full got g=%b v=%b idle=%b exp 0/1/0", wr_if.grant, ami_if.reqValid, idle);
        else passed++;
        next_cycle();
        ami_if.grant = 1'b1;
        #1;
        total++;
        if (wr_if.grant !== 1'b0) $display("FAIL quiesce_drain_grant got %b exp 0", wr_if.grant);
        else passed++;
        next_cycle();
        #1;
        total++;
        if (ami_if.reqValid !== 1'b0 || idle !== 1'b1 || wr_if.grant !== 1'b0)
            $display("FAIL quiesce_idle got v=%b idle=%b g=%b exp 0/1/0", ami_if.reqValid, idle, wr_if.grant);
        else passed++;
        next_cycle();
        quiesce = 1'b0;
        #1;
        total++;
        if (wr_if.grant !== 1'b1 || idle !== 1'b0)
            $display("FAIL quiesce_resume got g=%b idle=%b exp 1/0", wr_if.grant, idle);
        else passed++;
        next_cycle();
        total++;
        if (ami_if.reqValid !== 1'b1 || ami_if.req.addr !== 64'h408)
            $display("FAIL quiesce_out got v=%b a=%h exp v=1 a=408", ami_if.reqValid, ami_if.req.addr);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        ami_if.grant   = 1'b1;
        wr_if.reqValid = 1'b1;
        wr_if.req      = mk(64'h500, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            next_cycle();
        end
        total++;
        if (ami_if.reqValid !== 1'b1 || wr_cnt !== 32'd5)
            $display("FAIL areset_pre got v=%b cnt=%0d exp 1/5", ami_if.reqValid, wr_cnt);
        else passed++;
        rd_if.reqValid = 1'b1;
        rd_if.req      = mk(64'h600, 1'b1, 1'b0);
        rst            = 1'b1;
        #1;
        total++;
        if (ami_if.reqValid !== 1'b0 || wr_cnt !== 32'd0 || rd_cnt !== 32'd0)
            $display("FAIL areset_clear got v=%b cnt=%0d/%0d exp 0/0/0", ami_if.reqValid, rd_cnt, wr_cnt);
        else passed++;
        next_cycle();
        rst = 1'b0;
        #1;
        total++;
        if (rd_if.grant !== 1'b1 || wr_if.grant !== 1'b0)
            $display("FAIL areset_tie got rd=%b wr=%b exp 1/0", rd_if.grant, wr_if.grant);
        else passed++;
        next_cycle();
    endtask

    task automatic test_invalid_req();
        do_reset();
        ami_if.grant   = 1'b1;
        wr_if.reqValid = 1'b1;
        wr_if.req      = mk(64'h700, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (wr_if.grant !== 1'b0 || ami_if.reqValid !== 1'b0 || wr_cnt !== 32'd0)
                $display("FAIL invalid_req c%0d got g=%b v=%b cnt=%0d exp 0/0/0",
                         c, wr_if.grant, ami_if.reqValid, wr_cnt);
            else passed++;
            next_cycle();
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_rd_only();
        test_both_burst();
        test_stall();
        test_quiesce();
        test_async_reset();
        test_invalid_req();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
